// File: rtl/mult_32bits_seq_if.sv
// Operand and product handshake bundle for the sequential 32x32 multiplier.
// The slave modport is the multiplier side and the master modport is the requester side.
interface mult_32bits_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] p;
    logic        busy;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/mult_32bits_seq.sv
// Unsigned 32x32->64 shift-add multiplier: one add-and-shift step per clock for 32 clocks,
// built around a single 32-bit ripple adder. Operands and product use valid/ready handshakes.
module mult_32bits_seq (
    input  logic               clk,
    input  logic               rst_n,
    mult_32bits_seq_if.slave   bus_s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [31:0] sum;
    logic        co;

    // hi -> adder -> hi is the critical path of the block.
    adder_32bits u_adder (
        .a   (hi_q),
        .b   (mcand_q),
        .ci  (1'b0),
        .sum (sum),
        .co  (co)
    );

    // NOTE: every register is reset, so an abort mid-operation leaves p at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments let all registers sample the same pre-edge values.
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
        state_d         = state_q;
        mcand_d         = mcand_q;
        hi_d            = hi_q;
        lo_d            = lo_q;
        cnt_d           = cnt_q;
        bus_s.in_ready  = 1'b0;
        bus_s.out_valid = 1'b0;
        bus_s.busy      = 1'b0;
        bus_s.p         = {hi_q, lo_q};

        case (state_q)
            IDLE: begin
                bus_s.in_ready = 1'b1;
                if (bus_s.in_valid) begin
                    mcand_d = bus_s.a;
                    hi_d    = '0;
                    lo_d    = bus_s.b;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                bus_s.busy = 1'b1;
                // Adder carry lands in hi[31]; the consumed multiplier bit falls out of lo[0].
                if (lo_q[0]) begin
                    {hi_d, lo_d} = {co, sum, lo_q[31:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus_s.busy      = 1'b1;
                bus_s.out_valid = 1'b1;
                if (bus_s.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

module adder_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] sum,
    output logic        co
);
    assign {co, sum} = {1'b0, a} + {1'b0, b} + {32'd0, ci};
endmodule

// File: tb/tb_mult_32bits_seq.sv
// Self-checking bench for mult_32bits_seq: directed corner products, backpressure, reset abort
// and random operands, all compared against a plain 64-bit multiply.
module tb_mult_32bits_seq;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mult_32bits_seq_if bus ();

    mult_32bits_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_s (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait for product, optional stall, handshake out.
    task automatic do_mul(input logic [31:0] x, input logic [31:0] y, input bit early_ready,
                          input int stall, input bit noise);
        logic [63:0] exp_p;
        int          lat;
        int          w;
        exp_p = 64'(x) * 64'(y);

        w = 0;
        while (!bus.in_ready && w < 100) begin
            cycle();
            w++;
        end
        check("accept_ready", 64'(bus.in_ready), 64'd1);

        bus.in_valid  = 1'b1;
        bus.a         = x;
        bus.b         = y;
        bus.out_ready = early_ready;
        cycle();
        bus.in_valid  = 1'b0;

        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            if (noise) begin
                check("calc_ready_low", 64'(bus.in_ready), 64'd0);
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.a        = $urandom;
                bus.b        = $urandom;
            end
            cycle();
            lat++;
        end
        check("latency", 64'(lat), 64'd32);
        check("product", bus.p, exp_p);
        check("busy_done", 64'(bus.busy), 64'd1);

        if (stall > 0) begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                if (noise) begin
                    bus.in_valid = 1'($urandom_range(0, 1));
                    bus.a        = $urandom;
                    bus.b        = $urandom;
                end
                cycle();
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                check("stall_p", bus.p, exp_p);
            end
        end

        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("release_valid", 64'(bus.out_valid), 64'd0);
        check("release_ready", 64'(bus.in_ready), 64'd1);
        check("release_busy", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        #2;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_p", bus.p, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // 3 x 5 with out_ready held high from the start.
        do_mul(32'd3, 32'd5, 1'b1, 0, 1'b0);
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
        do_mul(32'd0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        do_mul(32'h1234_5678, 32'd1, 1'b0, 0, 1'b0);
        // Operand noise during CALC/DONE plus a 10-cycle output stall.
        do_mul(32'hCAFE_0001, 32'h0000_BABE, 1'b0, 10, 1'b1);

        // Reset abort in the middle of the iteration sequence.
        bus.in_valid = 1'b1;
        bus.a        = 32'hAAAA_5555;
        bus.b        = 32'h1357_9BDF;
        cycle();
        bus.in_valid = 1'b0;
        repeat (15) cycle();
        check("mid_calc_busy", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_p", bus.p, 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        do_mul(32'h0001_0000, 32'h0001_0000, 1'b1, 0, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = $urandom;
            y = $urandom;
            if (k % 97 == 0) x = 32'hFFFF_FFFF;
            if (k % 89 == 0) y = 32'h8000_0000;
            do_mul(x, y, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
